// File: rtl/traffic_light_monitor_pkg.sv
// Shared types for the four-way traffic light monitor: light encoding, error
// codes, direction indices and small classification helpers.
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2,
    LEFT   = 2'd3
  } traffic_light;

  typedef enum logic [2:0] {
    NONE          = 3'd0,
    ILLEGAL_TRANS = 3'd1,
    CONFLICT      = 3'd2,
    LEFT_CONFLICT = 3'd3,
    SHORT_GREEN   = 3'd4,
    SHORT_YELLOW  = 3'd5,
    RED_TIMEOUT   = 3'd6
  } mon_err_e;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_S = 2'd1,
    DIR_E = 2'd2,
    DIR_W = 2'd3
  } light_dir_e;

  // Any aspect other than RED lets traffic into the junction.
  function automatic logic is_go(traffic_light l);
    return l != RED;
  endfunction

  function automatic logic legal_move(traffic_light p, traffic_light c);
    return ((p == GREEN)  && (c == YELLOW)) ||
           ((p == YELLOW) && (c == RED))    ||
           ((p == RED)    && (c == GREEN))  ||
           ((p == RED)    && (c == LEFT))   ||
           ((p == LEFT)   && (c == YELLOW));
  endfunction

  function automatic light_dir_e first_dir(logic [3:0] v);
    if (v[0])      return DIR_N;
    else if (v[1]) return DIR_S;
    else if (v[2]) return DIR_E;
    else           return DIR_W;
  endfunction

endpackage

// File: rtl/traffic_light_monitor_channel.sv
// Per-direction sequencing checker: remembers the previous aspect and how long
// it has been held, and flags illegal moves, short dwells and red starvation.
module light_channel_checker
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 4,
  parameter int MIN_YELLOW = 2,
  parameter int MAX_RED    = 64,
  parameter int CNT_W      = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       primed_i,
  input  logic [1:0] cur_i,
  output logic       illegal_o,
  output logic       short_green_o,
  output logic       short_yellow_o,
  output logic       red_timeout_o
);

  localparam logic [CNT_W-1:0] DWELL_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_G     = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MIN_Y     = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] MAX_R     = CNT_W'(MAX_RED);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  traffic_light     cur_l;
  traffic_light     prev_q, prev_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;

  assign cur_l = traffic_light'(cur_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q  <= RED;
      dwell_q <= '0;
    end else begin
      prev_q  <= prev_d;
      dwell_q <= dwell_d;
    end
  end

  always_comb begin
    prev_d         = prev_q;
    dwell_d        = dwell_q;
    illegal_o      = 1'b0;
    short_green_o  = 1'b0;
    short_yellow_o = 1'b0;
    red_timeout_o  = 1'b0;
    if (en_i) begin
      prev_d = cur_l;
      if (!primed_i) begin
        dwell_d = ONE;
      end else if (cur_l == prev_q) begin
        // A saturated counter never re-reaches MAX_RED, so the timeout fires once.
        if (dwell_q != DWELL_MAX) begin
          dwell_d       = dwell_q + ONE;
          red_timeout_o = (cur_l == RED) && (dwell_d == MAX_R);
        end
      end else begin
        dwell_d        = ONE;
        illegal_o      = !legal_move(prev_q, cur_l);
        short_green_o  = (prev_q == GREEN)  && (dwell_q < MIN_G);
        short_yellow_o = (prev_q == YELLOW) && (dwell_q < MIN_Y);
      end
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive safety monitor for a four-way junction: per-direction sequencing plus
// cross-axis conflict checks, sticky first-error capture and a violation counter.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 4,
  parameter int MIN_YELLOW = 2,
  parameter int MAX_RED    = 64,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             err_clr,
  input  logic [1:0]       north,
  input  logic [1:0]       south,
  input  logic [1:0]       east,
  input  logic [1:0]       west,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [1:0]       err_dir,
  output logic [CNT_W-1:0] viol_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]   raw [4];
  traffic_light lights [4];
  logic [3:0]   go, left_c, illegal, short_g, short_y, red_to;
  logic         chk, conflict, viol;
  mon_err_e     viol_code;
  light_dir_e   viol_dir;

  logic             primed_q, primed_d;
  logic             err_q, err_d;
  mon_err_e         err_code_q, err_code_d;
  light_dir_e       err_dir_q, err_dir_d;
  logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;

  assign raw[0] = north;
  assign raw[1] = south;
  assign raw[2] = east;
  assign raw[3] = west;

  for (genvar g = 0; g < 4; g++) begin : g_chan
    assign lights[g] = traffic_light'(raw[g]);
    light_channel_checker #(
      .MIN_GREEN (MIN_GREEN),
      .MIN_YELLOW(MIN_YELLOW),
      .MAX_RED   (MAX_RED),
      .CNT_W     (CNT_W)
    ) u_chk (
      .clk_i         (clk),
      .rst_i         (rst),
      .en_i          (en),
      .primed_i      (primed_q),
      .cur_i         (raw[g]),
      .illegal_o     (illegal[g]),
      .short_green_o (short_g[g]),
      .short_yellow_o(short_y[g]),
      .red_timeout_o (red_to[g])
    );
  end

  assign chk = en && primed_q;

  always_comb begin
    go     = '0;
    left_c = '0;
    for (int d = 0; d < 4; d++) begin
      go[d] = is_go(lights[d]);
      // Partner head across the same axis: N<->S, E<->W.
      left_c[d] = chk && (lights[d] == LEFT) && (lights[d ^ 1] == GREEN);
    end
    conflict = chk && (go[0] || go[1]) && (go[2] || go[3]);
  end

  always_comb begin
    viol_code = NONE;
    viol_dir  = DIR_N;
    if (conflict) begin
      viol_code = CONFLICT;
      viol_dir  = first_dir(go);
    end else if (|left_c) begin
      viol_code = LEFT_CONFLICT;
      viol_dir  = first_dir(left_c);
    end else if (|illegal) begin
      viol_code = ILLEGAL_TRANS;
      viol_dir  = first_dir(illegal);
    end else if (|short_g) begin
      viol_code = SHORT_GREEN;
      viol_dir  = first_dir(short_g);
    end else if (|short_y) begin
      viol_code = SHORT_YELLOW;
      viol_dir  = first_dir(short_y);
    end else if (|red_to) begin
      viol_code = RED_TIMEOUT;
      viol_dir  = first_dir(red_to);
    end
    viol = (viol_code != NONE);
  end

  always_comb begin
    primed_d   = en;
    err_d      = err_q;
    err_code_d = err_code_q;
    err_dir_d  = err_dir_q;
    viol_cnt_d = viol_cnt_q;
    if (err_clr) begin
      // A violation in the clearing cycle becomes the new first error.
      err_d      = viol;
      err_code_d = viol_code;
      err_dir_d  = viol_dir;
      viol_cnt_d = viol ? CNT_ONE : '0;
    end else if (viol) begin
      if (!err_q) begin
        err_d      = 1'b1;
        err_code_d = viol_code;
        err_dir_d  = viol_dir;
      end
      if (viol_cnt_q != CNT_MAX) viol_cnt_d = viol_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed_q   <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= NONE;
      err_dir_q  <= DIR_N;
      viol_cnt_q <= '0;
    end else begin
      primed_q   <= primed_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      err_dir_q  <= err_dir_d;
      viol_cnt_q <= viol_cnt_d;
    end
  end

  assign err      = err_q;
  assign err_code = err_code_q;
  assign err_dir  = err_dir_q;
  assign viol_cnt = viol_cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus random light traffic,
// scored against a run-length reference model through an expected-output queue.
module tb_traffic_light_monitor;

  localparam int G = 0, Y = 1, R = 2, L = 3;
  localparam int MIN_GREEN = 4, MIN_YELLOW = 2, MAX_RED = 64, CNT_MAX = 255;

  // clock / reset / DUT
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       err_clr = 1'b0;
  logic [1:0] north = 2'd2, south = 2'd2, east = 2'd2, west = 2'd2;
  logic       err;
  logic [2:0] err_code;
  logic [1:0] err_dir;
  logic [7:0] viol_cnt;

  always #5 clk = ~clk;

  traffic_light_monitor dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .err_clr (err_clr),
    .north   (north),
    .south   (south),
    .east    (east),
    .west    (west),
    .err     (err),
    .err_code(err_code),
    .err_dir (err_dir),
    .viol_cnt(viol_cnt)
  );

  // reference model: each head is described by its current aspect and run length
  logic [13:0] exp_q[$];
  int  n_checks = 0, n_pass = 0;
  bit  m_primed = 0;
  int  m_prev[4] = '{R, R, R, R};
  int  m_run[4] = '{0, 0, 0, 0};
  bit  m_err = 0;
  int  m_code = 0, m_dir = 0, m_cnt = 0;
  int  best_key;
  bit  nxt_rst = 1, nxt_en = 0, nxt_clr = 0;
  int  rank_code[6] = '{2, 3, 1, 4, 5, 6};

  function automatic bit legal(int p, int c);
    return (p == G && c == Y) || (p == Y && c == R) || (p == R && (c == G || c == L)) ||
           (p == L && c == Y);
  endfunction

  function automatic int rank_of(int code);
    for (int i = 0; i < 6; i++) if (rank_code[i] == code) return i;
    return 99;
  endfunction

  task automatic consider(input int code, input int dir);
    int key;
    key = rank_of(code) * 4 + dir;
    if (key < best_key) best_key = key;
  endtask

  task automatic model_step(input bit r, input bit e, input bit c, input int cur[4]);
    bit go[4];
    bit viol;
    int vcode, vdir;
    if (r) begin
      m_primed = 0; m_err = 0; m_code = 0; m_dir = 0; m_cnt = 0;
      for (int d = 0; d < 4; d++) begin m_prev[d] = R; m_run[d] = 0; end
    end else begin
      best_key = 1000;
      if (e && m_primed) begin
        for (int d = 0; d < 4; d++) go[d] = (cur[d] != R);
        if ((go[0] || go[1]) && (go[2] || go[3])) begin
          for (int d = 3; d >= 0; d--) if (go[d]) vdir = d;
          consider(2, vdir);
        end
        for (int d = 0; d < 4; d++)
          if (cur[d] == L && cur[d ^ 1] == G) consider(3, d);
        for (int d = 0; d < 4; d++) begin
          if (cur[d] != m_prev[d]) begin
            if (!legal(m_prev[d], cur[d])) consider(1, d);
            if (m_prev[d] == G && m_run[d] < MIN_GREEN) consider(4, d);
            if (m_prev[d] == Y && m_run[d] < MIN_YELLOW) consider(5, d);
            m_run[d] = 1;
          end else if (m_run[d] < CNT_MAX) begin
            m_run[d]++;
            if (cur[d] == R && m_run[d] == MAX_RED) consider(6, d);
          end
          m_prev[d] = cur[d];
        end
      end else if (e) begin
        for (int d = 0; d < 4; d++) begin m_prev[d] = cur[d]; m_run[d] = 1; end
      end
      m_primed = e;
      viol  = (best_key < 1000);
      vcode = viol ? rank_code[best_key / 4] : 0;
      vdir  = viol ? best_key % 4 : 0;
      if (c) begin
        m_err = viol; m_code = vcode; m_dir = vdir; m_cnt = viol ? 1 : 0;
      end else if (viol) begin
        if (!m_err) begin m_err = 1; m_code = vcode; m_dir = vdir; end
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end
    exp_q.push_back({m_err, 3'(m_code), 2'(m_dir), 8'(m_cnt)});
  endtask

  // driver tasks: every input changes together on the falling edge
  task automatic step(input int n, input int s, input int e, input int w);
    int cur[4];
    @(negedge clk);
    rst = nxt_rst; en = nxt_en; err_clr = nxt_clr;
    north = n[1:0]; south = s[1:0]; east = e[1:0]; west = w[1:0];
    cur = '{n, s, e, w};
    model_step(nxt_rst, nxt_en, nxt_clr, cur);
  endtask

  task automatic hold(input int n, input int s, input int e, input int w, input int k);
    repeat (k) step(n, s, e, w);
  endtask

  task automatic clear_all();
    nxt_clr = 1; step(R, R, R, R); nxt_clr = 0;
  endtask

  function automatic int succ(int p);
    case (p)
      G: return Y;
      Y: return R;
      R: return ($urandom_range(0, 1) == 0) ? G : L;
      default: return Y;
    endcase
  endfunction

  // scoreboard monitor
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  initial begin
    logic [13:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("err", int'(err), int'(e[13]));
        check("err_code", int'(err_code), int'(e[12:10]));
        check("err_dir", int'(err_dir), int'(e[9:8]));
        check("viol_cnt", int'(viol_cnt), int'(e[7:0]));
      end
    end
  end

  // stimulus
  initial begin
    int cur[4];
    int mode;
    hold(R, R, R, R, 2);
    nxt_rst = 0; nxt_en = 1;

    // legal two-phase cycle
    step(R, R, R, R);
    repeat (3) begin
      hold(G, G, R, R, 5); hold(Y, Y, R, R, 2); hold(R, R, R, R, 1);
      hold(R, R, G, G, 5); hold(R, R, Y, Y, 2); hold(R, R, R, R, 1);
    end

    // GREEN straight to RED on north
    hold(G, G, R, R, 5); step(R, G, R, R); hold(R, Y, R, R, 2); hold(R, R, R, R, 2);
    clear_all();

    // cross-axis conflict for several cycles
    hold(G, R, G, R, 3); hold(Y, R, Y, R, 2); hold(R, R, R, R, 2);
    clear_all();

    // short south green
    hold(R, G, R, R, 2); hold(R, Y, R, R, 2); hold(R, R, R, R, 1);
    clear_all();

    // west starvation, then a conflict while the first error is held
    nxt_en = 0; step(R, R, R, R); nxt_en = 1;
    hold(R, R, G, R, 5); hold(R, R, Y, R, 2); hold(R, R, R, R, 1);
    hold(G, G, R, R, 70);
    hold(G, G, G, R, 2); hold(Y, Y, Y, R, 2); hold(R, R, R, R, 2);
    clear_all();

    // clear alone, clear colliding with a conflict, reset mid-yellow
    clear_all();
    step(R, R, R, R);
    nxt_clr = 1; step(G, R, G, R); nxt_clr = 0;
    hold(Y, R, Y, R, 2); hold(R, R, R, R, 2);
    clear_all();
    hold(G, G, R, R, 5); step(Y, Y, R, R);
    nxt_rst = 1; step(Y, Y, R, R); nxt_rst = 0;
    hold(Y, Y, R, R, 2); hold(R, R, R, R, 1);
    clear_all();

    // random traffic: full-random, single-axis mostly-legal blocks
    cur = '{R, R, R, R};
    for (int blk = 0; blk < 8; blk++) begin
      mode = $urandom_range(0, 2);
      for (int i = 0; i < 80; i++) begin
        nxt_rst = ($urandom_range(0, 199) == 0);
        nxt_en  = ($urandom_range(0, 19) != 0);
        nxt_clr = ($urandom_range(0, 24) == 0);
        for (int d = 0; d < 4; d++) begin
          if (mode == 1 && d >= 2) cur[d] = R;
          else if (mode == 2 && d < 2) cur[d] = R;
          else if ($urandom_range(0, 3) == 0) begin
            if (mode == 0 || $urandom_range(0, 4) == 0) cur[d] = $urandom_range(0, 3);
            else cur[d] = succ(cur[d]);
          end
        end
        step(cur[0], cur[1], cur[2], cur[3]);
      end
    end
    nxt_rst = 0; nxt_en = 1; nxt_clr = 0;

    // final report
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
